ucode_sequencer: RTL and testbench

- Sits between fetch and decode.
- Detects multiply instructions (mul/muls, immediate/register forms) in the fetched stream, stalls fetch, and drives the microcode ROM inputs. The ROM inputs are mul_opcode, immediate, reg1, reg2, dest_reg and ghost_pc.
- Forwards the ROM's micro-ops to decode one at a time. It resolves the in-sequence ghost branch (bne) using feedback from execute.
- Non-multiply instructions pass straight through.

---
 rtl/ucode_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_ucode_sequencer.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucode_sequencer.sv
// Multiply-expansion sequencer between fetch and decode.
// Stalls fetch, walks a microcode ROM slot and resolves its ghost branch.
module ucode_sequencer #(
  parameter int         UCODE_LEN = 5,
  parameter logic [6:0] BR_OPCODE = 7'b1100001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_in,
  input  logic        instr_valid,
  input  logic        decode_ready,
  input  logic        flush,
  input  logic [31:0] ucode_instr,
  input  logic        br_resolve_valid,
  input  logic        br_taken,
  output logic [6:0]  mul_opcode,
  output logic [15:0] immediate,
  output logic [3:0]  reg1,
  output logic [3:0]  reg2,
  output logic [3:0]  dest_reg,
  output logic [3:0]  ghost_pc,
  output logic        fetch_stall,
  output logic [31:0] instr_out,
  output logic        instr_out_valid,
  output logic        ucode_busy,
  output logic        ucode_err
);

  localparam int PW = $clog2(4 * UCODE_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_ISSUE,
    S_WAIT
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   pc_q, pc_d;
  logic [PW-1:0]   base_q, base_d;
  logic [3:0]      off_q, off_d;
  logic [6:0]      opc_q, opc_d;
  logic [15:0]     imm_q, imm_d;
  logic [3:0]      r1_q, r1_d;
  logic [3:0]      r2_q, r2_d;
  logic [3:0]      rd_q, rd_d;
  logic            err_q, err_d;

  logic            is_mul;
  logic [1:0]      slot;
  logic [PW-1:0]   base_new;
  logic [PW-1:0]   last;
  logic [PW-1:0]   pc_inc;
  logic [PW:0]     tgt;
  logic            in_rng;
  logic            is_br;
  logic            ovld;
  logic            stall;

  always_comb begin
    is_mul = 1'b1;
    slot   = 2'd0;
    unique case (instr_in[31:25])
      7'b0010000: slot = 2'd0;
      7'b0011000: slot = 2'd1;
      7'b0110000: slot = 2'd2;
      7'b0111000: slot = 2'd3;
      default:    is_mul = 1'b0;
    endcase
  end

  assign base_new = PW'(slot) * PW'(UCODE_LEN);
  assign last     = base_q + PW'(UCODE_LEN - 1);
  assign pc_inc   = pc_q + PW'(1);
  // One extra bit keeps a negative target distinguishable from in-range.
  assign tgt      = {1'b0, pc_q} + {{(PW-3){off_q[3]}}, off_q};
  assign in_rng   = (tgt >= {1'b0, base_q}) && (tgt <= {1'b0, last});
  assign is_br    = ucode_instr[31:25] == BR_OPCODE;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    base_d    = base_q;
    off_d     = off_q;
    opc_d     = opc_q;
    imm_d     = imm_q;
    r1_d      = r1_q;
    r2_d      = r2_q;
    rd_d      = rd_q;
    err_d     = err_q;
    ovld      = 1'b0;
    stall     = 1'b0;
    instr_out = ucode_instr;
    if (flush) begin
      state_d = S_IDLE;
      pc_d    = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          instr_out = instr_in;
          if (instr_valid && is_mul) begin
            stall   = 1'b1;
            opc_d   = instr_in[31:25];
            imm_d   = instr_in[15:0];
            r1_d    = instr_in[20:17];
            r2_d    = instr_in[16:13];
            rd_d    = instr_in[24:21];
            base_d  = base_new;
            pc_d    = base_new;
            state_d = S_PRIME;
          end else begin
            ovld  = instr_valid;
            stall = instr_valid & ~decode_ready;
          end
        end
        S_PRIME: begin
          stall   = 1'b1;
          state_d = S_ISSUE;
        end
        S_ISSUE: begin
          ovld  = 1'b1;
          stall = 1'b1;
          if (decode_ready) begin
            if (is_br) begin
              off_d   = ucode_instr[3:0];
              state_d = S_WAIT;
            end else if (pc_q == last) begin
              stall   = 1'b0;
              state_d = S_IDLE;
            end else begin
              pc_d    = pc_inc;
              state_d = S_PRIME;
            end
          end
        end
        S_WAIT: begin
          stall = 1'b1;
          if (br_resolve_valid) begin
            if (br_taken) begin
              if (in_rng) begin
                pc_d    = tgt[PW-1:0];
                state_d = S_PRIME;
              end else begin
                err_d   = 1'b1;
                stall   = 1'b0;
                pc_d    = '0;
                state_d = S_IDLE;
              end
            end else if (pc_q == last) begin
              stall   = 1'b0;
              state_d = S_IDLE;
            end else begin
              pc_d    = pc_inc;
              state_d = S_PRIME;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      base_q  <= '0;
      off_q   <= '0;
      opc_q   <= '0;
      imm_q   <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      base_q  <= base_d;
      off_q   <= off_d;
      opc_q   <= opc_d;
      imm_q   <= imm_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  assign mul_opcode      = opc_q;
  assign immediate       = imm_q;
  assign reg1            = r1_q;
  assign reg2            = r2_q;
  assign dest_reg        = rd_q;
  assign ghost_pc        = pc_q[3:0];
  assign ucode_err       = err_q;
  assign ucode_busy      = state_q != S_IDLE;
  assign fetch_stall     = stall;
  assign instr_out_valid = ovld & rst;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Randomized bench for ucode_sequencer against a micro-op stream model.
// The model expands each multiply into its expected issued ghost_pc list.
module tb_ucode_sequencer;

  localparam logic [6:0] BR = 7'b1100001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_in;
  logic        instr_valid;
  logic        decode_ready;
  logic        flush;
  logic [31:0] ucode_instr;
  logic        br_resolve_valid;
  logic        br_taken;
  logic [6:0]  mul_opcode;
  logic [15:0] immediate;
  logic [3:0]  reg1, reg2, dest_reg, ghost_pc;
  logic        fetch_stall, instr_out_valid, ucode_busy, ucode_err;
  logic [31:0] instr_out;

  ucode_sequencer dut (
    .clk              (clk),
    .rst              (rst_n),
    .instr_in         (instr_in),
    .instr_valid      (instr_valid),
    .decode_ready     (decode_ready),
    .flush            (flush),
    .ucode_instr      (ucode_instr),
    .br_resolve_valid (br_resolve_valid),
    .br_taken         (br_taken),
    .mul_opcode       (mul_opcode),
    .immediate        (immediate),
    .reg1             (reg1),
    .reg2             (reg2),
    .dest_reg         (dest_reg),
    .ghost_pc         (ghost_pc),
    .fetch_stall      (fetch_stall),
    .instr_out        (instr_out),
    .instr_out_valid  (instr_out_valid),
    .ucode_busy       (ucode_busy),
    .ucode_err        (ucode_err)
  );

  always #5 clk = ~clk;

  logic [31:0] rom [16];
  always @(posedge clk) ucode_instr <= rom[ghost_pc];

  int n_pass = 0;
  int n_total = 0;
  int exp_pcs[$];
  bit exp_br[$];
  bit pat[$];
  bit exp_err;
  int exp_end;
  bit err_m = 0;
  int busy_cycles;

  function automatic logic [31:0] mk_op(int i);
    logic [31:0] w;
    w = {7'b0000001, 9'(i), 16'(i * 37 + 1)};
    return w;
  endfunction

  function automatic logic [31:0] mk_br(logic [3:0] off);
    logic [31:0] w;
    w = {BR, 9'h0A5, 12'hFFF, off};
    return w;
  endfunction

  function automatic bit is_mul_op(logic [6:0] op);
    return op == 7'b0010000 || op == 7'b0011000 ||
           op == 7'b0110000 || op == 7'b0111000;
  endfunction

  function automatic logic [6:0] slot_op(int s);
    logic [6:0] t [4];
    t[0] = 7'b0010000; t[1] = 7'b0011000;
    t[2] = 7'b0110000; t[3] = 7'b0111000;
    return t[s];
  endfunction

  task automatic rom_default();
    for (int i = 0; i < 16; i++) rom[i] = mk_op(i);
    rom[4] = mk_br(4'hD);
  endtask

  // Expected issue stream: walk the slot using the branch rules directly.
  task automatic model_run(input int slot);
    int base, lst, pc, steps, so, t;
    logic [31:0] w;
    bit tk;
    base = slot * 5;
    lst = base + 4;
    pc = base;
    steps = 0;
    exp_pcs.delete();
    exp_br.delete();
    exp_err = 0;
    forever begin
      steps++;
      exp_pcs.push_back(pc);
      w = rom[pc % 16];
      if (w[31:25] == BR) begin
        if (pat.size() > 0) tk = pat.pop_front();
        else tk = (steps < 30) && ($urandom_range(2) == 0);
        exp_br.push_back(tk);
        if (tk) begin
          so = int'(w[3:0]);
          if (so >= 8) so -= 16;
          t = pc + so;
          if (t >= base && t <= lst) begin
            pc = t;
            continue;
          end
          exp_err = 1;
          pc = 0;
          break;
        end
      end
      if (pc == lst) break;
      pc++;
    end
    exp_end = pc;
  endtask

  task automatic drive_mul(input logic [31:0] mi, input int rdy_pct,
                           input int hold_n);
    int idx, bidx, cyc, hold_left;
    bit pending, done, acc_br;
    idx = 0; bidx = 0; cyc = 0; pending = 0; done = 0;
    hold_left = hold_n;
    busy_cycles = 0;
    @(negedge clk);
    instr_in = mi;
    instr_valid = 1'b1;
    while (!done && cyc < 400) begin
      if (cyc > 0) instr_in = $urandom;
      decode_ready = $urandom_range(99) < rdy_pct;
      br_resolve_valid = pending ? 1'($urandom_range(1))
                                 : ($urandom_range(3) == 0);
      br_taken = pending ? exp_br[bidx] : 1'($urandom_range(1));
      #1;
      if (hold_left > 0 && ucode_busy && instr_out_valid) begin
        decode_ready = 1'b0;
        hold_left--;
        #1;
        n_total++;
        if (idx < exp_pcs.size() && instr_out === rom[exp_pcs[idx] % 16])
          n_pass++;
        else $display("FAIL hold_instr got %h idx %0d", instr_out, idx);
        n_total++;
        if (idx < exp_pcs.size() && ghost_pc === 4'(exp_pcs[idx]))
          n_pass++;
        else $display("FAIL hold_pc got %0d idx %0d", ghost_pc, idx);
      end
      cyc++;
      if (ucode_busy) busy_cycles++;
      acc_br = 0;
      if (ucode_busy && instr_out_valid && decode_ready) begin
        if (idx < exp_pcs.size()) begin
          n_total++;
          if (ghost_pc !== 4'(exp_pcs[idx]))
            $display("FAIL uop_pc[%0d] got %0d exp %0d", idx, ghost_pc,
                     exp_pcs[idx] % 16);
          else n_pass++;
          n_total++;
          if (instr_out !== rom[exp_pcs[idx] % 16])
            $display("FAIL uop_instr[%0d] got %h exp %h", idx, instr_out,
                     rom[exp_pcs[idx] % 16]);
          else n_pass++;
        end else begin
          n_total++;
          $display("FAIL extra_uop got pc %0d exp none", ghost_pc);
        end
        idx++;
        acc_br = instr_out[31:25] == BR;
      end
      if (pending && br_resolve_valid) begin
        pending = 0;
        bidx++;
      end
      if (acc_br) pending = 1;
      if (!fetch_stall) done = 1;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    instr_in = 32'h0;
    decode_ready = 1'b1;
    br_resolve_valid = 1'b0;
    err_m = err_m | exp_err;
    n_total++;
    if (!done) $display("FAIL seq_timeout got %0d cycles exp release", cyc);
    else n_pass++;
    n_total++;
    if (idx != exp_pcs.size())
      $display("FAIL uop_count got %0d exp %0d", idx, exp_pcs.size());
    else n_pass++;
    #1;
    n_total++;
    if (ucode_busy !== 1'b0) $display("FAIL end_busy got %b exp 0", ucode_busy);
    else n_pass++;
    n_total++;
    if (ghost_pc !== 4'(exp_end))
      $display("FAIL end_pc got %0d exp %0d", ghost_pc, exp_end % 16);
    else n_pass++;
    n_total++;
    if (ucode_err !== err_m) $display("FAIL err got %b exp %b", ucode_err, err_m);
    else n_pass++;
    n_total++;
    if ({mul_opcode, immediate, reg1, reg2, dest_reg} !==
        {mi[31:25], mi[15:0], mi[20:17], mi[16:13], mi[24:21]})
      $display("FAIL fields got %h/%h/%h/%h/%h exp %h", mul_opcode, immediate,
               reg1, reg2, dest_reg, mi);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    instr_in = 32'h4000_1234;
    instr_valid = 1'b1;
    decode_ready = 1'b1;
    br_resolve_valid = 1'b0;
    br_taken = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if (instr_out_valid !== 1'b0)
      $display("FAIL rst_valid got %b exp 0", instr_out_valid);
    else n_pass++;
    n_total++;
    if ({ghost_pc, mul_opcode, immediate, reg1, reg2, dest_reg, ucode_err,
         ucode_busy} !== '0)
      $display("FAIL rst_regs got %h/%h/%h err %b busy %b exp 0", ghost_pc,
               mul_opcode, immediate, ucode_err, ucode_busy);
    else n_pass++;
    rst_n = 1'b1;
    instr_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_passthrough();
    logic [31:0] w;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      w = $urandom;
      if (i == 0) w[31:25] = 7'b0100000;
      if (is_mul_op(w[31:25])) w[31:25] = 7'b0100000;
      instr_in = w;
      instr_valid = (i < 2) ? 1'b1 : 1'($urandom_range(1));
      decode_ready = (i == 0) ? 1'b1 : (i == 1) ? 1'b0
                                     : 1'($urandom_range(1));
      #1;
      n_total++;
      if ({instr_out, instr_out_valid} !== {w, instr_valid})
        $display("FAIL pass_out got %h/%b exp %h/%b", instr_out,
                 instr_out_valid, w, instr_valid);
      else n_pass++;
      n_total++;
      if ({fetch_stall, ucode_busy} !== {instr_valid & ~decode_ready, 1'b0})
        $display("FAIL pass_stall got %b busy %b exp %b", fetch_stall,
                 ucode_busy, instr_valid & ~decode_ready);
      else n_pass++;
    end
    @(negedge clk);
    instr_valid = 1'b0;
    decode_ready = 1'b1;
  endtask

  task automatic test_branch_loop();
    rom_default();
    pat = '{1, 1, 1, 0};
    model_run(0);
    drive_mul({7'b0010000, 4'd3, 4'd2, 1'b0, 16'd4}, 100, 0);
  endtask

  task automatic test_slot3_timing();
    rom_default();
    pat.delete();
    model_run(3);
    drive_mul({7'b0111000, 4'd9, 4'd7, 1'b1, 16'hBEEF}, 100, 0);
    n_total++;
    if (busy_cycles != 10)
      $display("FAIL slot3_cycles got %0d exp 10", busy_cycles);
    else n_pass++;
  endtask

  task automatic test_ready_stall();
    rom_default();
    pat.delete();
    model_run(1);
    drive_mul({7'b0011000, 4'd1, 4'd5, 1'b0, 16'h0077}, 100, 3);
  endtask

  task automatic test_err_flush();
    rom_default();
    rom[4] = mk_br(4'h8);
    pat = '{1};
    model_run(0);
    drive_mul({7'b0010000, 4'd6, 4'd1, 1'b0, 16'h0100}, 100, 0);
    @(negedge clk);
    flush = 1'b1;
    #1;
    n_total++;
    if ({instr_out_valid, fetch_stall} !== 2'b00)
      $display("FAIL flush_out got %b%b exp 00", instr_out_valid, fetch_stall);
    else n_pass++;
    @(negedge clk);
    flush = 1'b0;
    err_m = 0;
    #1;
    n_total++;
    if (ucode_err !== 1'b0) $display("FAIL err_clear got %b exp 0", ucode_err);
    else n_pass++;
  endtask

  task automatic test_reset_wait_br();
    bit seen;
    int cyc;
    rom_default();
    seen = 0;
    cyc = 0;
    @(negedge clk);
    instr_in = {7'b0010000, 4'd2, 4'd3, 1'b0, 16'd9};
    instr_valid = 1'b1;
    decode_ready = 1'b1;
    br_resolve_valid = 1'b0;
    while (!seen && cyc < 40) begin
      #1;
      seen = ucode_busy && instr_out_valid && instr_out[31:25] == BR;
      cyc++;
      @(negedge clk);
    end
    n_total++;
    if (!seen) $display("FAIL wait_br_timeout got %0d cycles exp branch", cyc);
    else n_pass++;
    rst_n = 1'b0;
    instr_valid = 1'b0;
    #1;
    n_total++;
    if ({ucode_busy, ghost_pc, instr_out_valid, fetch_stall, mul_opcode} !== '0)
      $display("FAIL rst_wait got busy %b pc %0d v %b s %b op %h exp 0",
               ucode_busy, ghost_pc, instr_out_valid, fetch_stall, mul_opcode);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    err_m = 0;
  endtask

  task automatic test_flush_issue();
    bit seen;
    int cyc;
    rom_default();
    seen = 0;
    cyc = 0;
    @(negedge clk);
    instr_in = {7'b0011000, 4'd4, 4'd4, 1'b0, 16'd1};
    instr_valid = 1'b1;
    decode_ready = 1'b0;
    while (!seen && cyc < 10) begin
      #1;
      seen = ucode_busy && instr_out_valid;
      cyc++;
      if (!seen) @(negedge clk);
    end
    n_total++;
    if (!seen) $display("FAIL issue_timeout got %0d cycles exp issue", cyc);
    else n_pass++;
    flush = 1'b1;
    decode_ready = 1'b1;
    #1;
    n_total++;
    if ({instr_out_valid, fetch_stall} !== 2'b00)
      $display("FAIL flush_issue got %b%b exp 00", instr_out_valid, fetch_stall);
    else n_pass++;
    @(negedge clk);
    flush = 1'b0;
    instr_valid = 1'b0;
    #1;
    n_total++;
    if ({ucode_busy, ghost_pc} !== 5'b0)
      $display("FAIL flush_state got busy %b pc %0d exp 0", ucode_busy, ghost_pc);
    else n_pass++;
  endtask

  task automatic test_random();
    int s;
    logic [31:0] mi;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++)
        rom[i] = ($urandom_range(3) == 0) ? mk_br(4'($urandom))
                                          : mk_op($urandom_range(500));
      pat.delete();
      s = $urandom_range(3);
      mi = $urandom;
      mi[31:25] = slot_op(s);
      model_run(s);
      drive_mul(mi, 60, $urandom_range(2));
      if ($urandom_range(2) == 0) begin
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        err_m = 0;
      end
    end
  endtask

  initial begin
    rom_default();
    test_reset();
    test_passthrough();
    test_branch_loop();
    test_slot3_timing();
    test_ready_stall();
    test_err_flush();
    test_reset_wait_br();
    test_flush_issue();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
